game_mem_arbiter: RTL and testbench
===================================

// Module: game_mem_arbiter
// PURPOSE
//   Two-requester round-robin arbiter that shares the 4-word x 32-bit single-port
//   on-chip RAM (1-cycle registered-address read) between master 0 (CPU) and
//   master 1 (game logic). Each side is an Avalon-MM slave with waitrequest and
//   readdatavalid. The RAM side is an Avalon-MM master port. One transaction is
//   in flight at a time; commands to the RAM are registered.
// PARAMETERS
//   ADDR_W  2   word address width of RAM and both requesters
//   DATA_W  32  data width
//   BE_W    4   byteenable width (DATA_W/8)
// PORTS
//   clk               in   1       system clock
//   reset_n           in   1       asynchronous active-low reset
//   m0_address        in   ADDR_W  requester 0 word address
//   m0_byteenable     in   BE_W    requester 0 byte lanes
//   m0_read           in   1       requester 0 read request
//   m0_write          in   1       requester 0 write request
//   m0_writedata      in   DATA_W  requester 0 write data
//   m0_waitrequest    out  1       low = m0 command accepted this cycle
//   m0_readdata       out  DATA_W  m0 read data, valid with m0_readdatavalid
//   m0_readdatavalid  out  1       one-cycle pulse per m0 read
//   m1_*              ---  ---     identical set for requester 1
//   mem_address       out  ADDR_W  RAM address (registered)
//   mem_byteenable    out  BE_W    RAM byte lanes (registered)
//   mem_chipselect    out  1       RAM select, one-cycle pulse per access
//   mem_write         out  1       RAM write qualifier (registered)
//   mem_writedata     out  DATA_W  RAM write data (registered)
//   mem_clken         out  1       RAM clock enable, constant 1
//   mem_readdata      in   DATA_W  RAM read data, valid cycle after chipselect
// BEHAVIOUR
//   - Reset (async, reset_n=0): state=IDLE; mem_* regs=0; mem_clken=1;
//     m*_readdata=0; m*_readdatavalid=0; last_grant=1 (m0 wins first tie).
//     A read in flight is discarded; no readdatavalid is issued for it.
//   - reqN = mN_read | mN_write. read+write together on one requester is
//     treated as a write; the read is ignored.
//   - FSM: IDLE -> ISSUE -> (write) IDLE | (read) RDATA -> IDLE.
//   - IDLE: if any reqN, choose winner: the only requester, or if both, the one
//     that did not hold last_grant. Winner's waitrequest is low this cycle
//     (combinational). Command is latched into mem_* and owner is recorded.
//     Update last_grant to the winner, then go to ISSUE. With no request, stay.
//   - ISSUE: mem_chipselect=1 for exactly this cycle. Write -> IDLE. Read ->
//     RDATA.
//   - RDATA: capture mem_readdata into owner's mN_readdata. Set the owner's
//     mN_readdatavalid=1 on the next cycle, for one cycle. Go to IDLE.
//   - In ISSUE and RDATA, both waitrequests are high. In IDLE, a non-requesting
//     or losing master sees waitrequest high.
//   - Latency from acceptance edge T: write hits RAM at T+1. Read data and
//     readdatavalid appear at T+3. Peak throughput: write 1 per 2 cycles,
//     read 1 per 3 cycles.
//   - A readdatavalid pulse may coincide with a new acceptance in IDLE.
//   - mN_readdata holds its value until the next read of that requester.
// TESTING
//   - Reset: reset_n=0 mid-read -> state IDLE, no readdatavalid, mem_chipselect=0,
//     mem_clken=1.
//   - Single write: m0 write addr=2 data=0xDEADBEEF be=0xF -> one mem_chipselect
//     pulse, mem_write=1, addr=2. A later m1 read addr=2 returns 0xDEADBEEF,
//     3 cycles after acceptance.
//   - Byte lanes: write 0x11223344 be=0xF, then 0xAA000000 be=0x8 to addr=1 ->
//     read returns 0xAA223344.
//   - Tie: m0 and m1 both read continuously from reset -> grants alternate
//     m0,m1,m0,m1. Each readdatavalid goes only to its owner.
//   - Hold: m1 requests while m0 transaction is in ISSUE/RDATA -> m1_waitrequest
//     stays high. m1 command must remain stable and is accepted in the next IDLE.
//   - Wrap/edge: reads at addr=3 then addr=0 -> correct data. A read+write asserted
//     together -> treated as write, and no readdatavalid.

Source files
------------

// File: rtl/game_mem_arbiter.sv
// rtl/game_mem_arbiter.sv - round-robin arbiter sharing one single-port RAM between two Avalon-MM requesters
// Only one transaction is in flight at a time, and every RAM command is registered.
module game_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t state;
  logic   last_grant;
  logic   owner;
  logic   is_read;
  logic   req0, req1, winner, accept;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    winner = 1'b0;
    if (req0 && req1)
      winner = ~last_grant;
    else if (req1)
      winner = 1'b1;
    accept = (state == IDLE) && (req0 || req1);
  end

  assign m0_waitrequest = ~(accept && !winner);
  assign m1_waitrequest = ~(accept && winner);
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      is_read          <= 1'b0;
      mem_address      <= '0;
      mem_byteenable   <= '0;
      mem_chipselect   <= 1'b0;
      mem_write        <= 1'b0;
      mem_writedata    <= '0;
      m0_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdata      <= '0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      mem_chipselect   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Write takes precedence when read and write are both asserted.
            mem_address    <= winner ? m1_address    : m0_address;
            mem_byteenable <= winner ? m1_byteenable : m0_byteenable;
            mem_writedata  <= winner ? m1_writedata  : m0_writedata;
            mem_write      <= winner ? m1_write      : m0_write;
            is_read        <= winner ? ~m1_write     : ~m0_write;
            owner          <= winner;
            last_grant     <= winner;
            mem_chipselect <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          state <= is_read ? RDATA : IDLE;
        end
        RDATA: begin
          if (owner) begin
            m1_readdata      <= mem_readdata;
            m1_readdatavalid <= 1'b1;
          end else begin
            m0_readdata      <= mem_readdata;
            m0_readdatavalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_mem_arbiter.sv
// tb/tb_game_mem_arbiter.sv - self-checking bench for game_mem_arbiter
// The reference model schedules transactions by cycle number against a shadow copy of the RAM.
module tb_game_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;

  always #5 clk = ~clk;

  game_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM with a registered read: data is valid the cycle after chipselect.
  logic [31:0] ram [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  logic [31:0] shadow [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  int          c, free_at, cs_cyc, lg;
  int          rdv_cyc [2];
  logic [31:0] rdv_dat [2];
  logic        cs_w;
  logic [1:0]  cs_a;
  logic [3:0]  cs_be;
  logic [31:0] cs_d;
  bit          pend [2], prd [2], pwr [2];
  logic [1:0]  pa [2];
  logic [3:0]  pbe [2];
  logic [31:0] pd [2];
  int          grants [$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    lg = 1; free_at = 0; cs_cyc = -10; c = 0;
    rdv_cyc[0] = -10; rdv_cyc[1] = -10;
    pend[0] = 0; pend[1] = 0;
  endtask

  task automatic post(input int m, input bit r, input bit w, input logic [1:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    pend[m] = 1; prd[m] = r; pwr[m] = w; pa[m] = a; pbe[m] = be; pd[m] = d;
  endtask

  // One clock: drive pending commands, check every output against the model, advance the model.
  task automatic cyc();
    bit idle, acc;
    int w;
    m0_read = pend[0] & prd[0]; m0_write = pend[0] & pwr[0];
    m0_address = pa[0]; m0_byteenable = pbe[0]; m0_writedata = pd[0];
    m1_read = pend[1] & prd[1]; m1_write = pend[1] & pwr[1];
    m1_address = pa[1]; m1_byteenable = pbe[1]; m1_writedata = pd[1];
    @(negedge clk);
    idle = (c >= free_at);
    acc  = idle && (pend[0] || pend[1]);
    w    = (pend[0] && pend[1]) ? 1 - lg : (pend[1] ? 1 : 0);
    check_bit("m0_waitrequest", m0_waitrequest, !(acc && w == 0));
    check_bit("m1_waitrequest", m1_waitrequest, !(acc && w == 1));
    check_bit("m0_readdatavalid", m0_readdatavalid, c == rdv_cyc[0]);
    check_bit("m1_readdatavalid", m1_readdatavalid, c == rdv_cyc[1]);
    if (c == rdv_cyc[0]) check_word("m0_readdata", m0_readdata, rdv_dat[0]);
    if (c == rdv_cyc[1]) check_word("m1_readdata", m1_readdata, rdv_dat[1]);
    check_bit("mem_chipselect", mem_chipselect, c == cs_cyc);
    if (c == cs_cyc) begin
      check_bit("mem_write", mem_write, cs_w);
      check_word("mem_address", {30'h0, mem_address}, {30'h0, cs_a});
      if (cs_w) begin
        check_word("mem_byteenable", {28'h0, mem_byteenable}, {28'h0, cs_be});
        check_word("mem_writedata", mem_writedata, cs_d);
      end
    end
    if (acc) begin
      grants.push_back(w);
      cs_cyc = c + 1; cs_w = pwr[w]; cs_a = pa[w]; cs_be = pbe[w]; cs_d = pd[w];
      if (pwr[w]) begin
        for (int b = 0; b < 4; b++)
          if (pbe[w][b]) shadow[pa[w]][8*b +: 8] = pd[w][8*b +: 8];
        free_at = c + 2;
      end else begin
        rdv_cyc[w] = c + 3;
        rdv_dat[w] = shadow[pa[w]];
        free_at = c + 3;
      end
      lg = w;
      pend[w] = 0;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic settle();
    int k = 0;
    while ((pend[0] || pend[1]) && k < 20) begin
      cyc();
      k++;
    end
    check_bit("settle_timeout", pend[0] || pend[1], 1'b0);
    repeat (4) cyc();
  endtask

  initial begin
    reset_n = 1'b1;
    {m0_read, m0_write, m1_read, m1_write} = 4'b0;
    m0_address = 0; m1_address = 0; m0_byteenable = 0; m1_byteenable = 0;
    m0_writedata = 0; m1_writedata = 0;
    model_reset();
    #2 reset_n = 1'b0;
    #10;
    check_bit("rst_chipselect", mem_chipselect, 1'b0);
    check_bit("rst_mem_write", mem_write, 1'b0);
    check_word("rst_mem_address", {30'h0, mem_address}, 32'h0);
    check_bit("rst_clken", mem_clken, 1'b1);
    check_word("rst_m0_readdata", m0_readdata, 32'h0);
    check_bit("rst_m1_rdv", m1_readdatavalid, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    post(0, 0, 1, 2'd2, 4'hF, 32'hDEADBEEF); settle();
    post(1, 1, 0, 2'd2, 4'h0, 32'h0);        settle();
    check_word("single_write_readback", m1_readdata, 32'hDEADBEEF);

    post(0, 0, 1, 2'd1, 4'hF, 32'h11223344); settle();
    post(0, 0, 1, 2'd1, 4'h8, 32'hAA000000); settle();
    post(0, 1, 0, 2'd1, 4'h0, 32'h0);        settle();
    check_word("byte_lanes", m0_readdata, 32'hAA223344);

    post(1, 0, 1, 2'd3, 4'hF, 32'h33333333); settle();
    post(1, 0, 1, 2'd0, 4'hF, 32'h000000A5); settle();
    post(0, 1, 0, 2'd3, 4'h0, 32'h0);        settle();
    check_word("wrap_addr3", m0_readdata, 32'h33333333);
    post(0, 1, 0, 2'd0, 4'h0, 32'h0);        settle();
    check_word("wrap_addr0", m0_readdata, 32'h000000A5);

    post(1, 1, 1, 2'd0, 4'hF, 32'h5A5A5A5A); settle();
    check_word("rw_hold_m1_readdata", m1_readdata, 32'hDEADBEEF);
    post(0, 1, 0, 2'd0, 4'h0, 32'h0);        settle();
    check_word("rw_as_write", m0_readdata, 32'h5A5A5A5A);

    post(0, 1, 0, 2'd2, 4'h0, 32'h0); cyc();
    post(1, 0, 1, 2'd2, 4'hF, 32'h12345678); settle();
    post(1, 1, 0, 2'd2, 4'h0, 32'h0); settle();
    check_word("hold_then_accept", m1_readdata, 32'h12345678);

    post(0, 1, 0, 2'd1, 4'h0, 32'h0); cyc();
    {m0_read, m0_write, m1_read, m1_write} = 4'b0;
    reset_n = 1'b0;
    #1;
    check_bit("midread_chipselect", mem_chipselect, 1'b0);
    check_bit("midread_m0_rdv", m0_readdatavalid, 1'b0);
    check_bit("midread_clken", mem_clken, 1'b1);
    check_word("midread_m0_readdata", m0_readdata, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    repeat (4) cyc();

    grants.delete();
    for (int i = 0; i < 12; i++) begin
      if (!pend[0]) post(0, 1, 0, 2'($urandom_range(0, 3)), 4'h0, 32'h0);
      if (!pend[1]) post(1, 1, 0, 2'($urandom_range(0, 3)), 4'h0, 32'h0);
      cyc();
    end
    settle();
    check_bit("tie_grant_count", grants.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check_word("tie_grant_order", grants[i], i % 2);

    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) == 0) begin
          int op;
          op = $urandom_range(0, 3);
          post(m, op != 2, op >= 2, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom);
        end
      end
      cyc();
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
